// File: rtl/seg_display_scanner.sv
// Multiplexed N-digit seven-segment scanner: per-digit slot timing, hex decode,
// leading-zero suppression, ghost blanking, PWM dimming and frame-coherent inputs.
module seg_display_scanner #(
  parameter int CLK_PER    = 10,
  parameter int REFR_RATE  = 1000,
  parameter int NUM_DIGITS = 4,
  parameter int BLANK_CYC  = 4,
  parameter int BRIGHT_W   = 3
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          enable,
  input  logic [4*NUM_DIGITS-1:0]       digits,
  input  logic [NUM_DIGITS-1:0]         dp,
  input  logic [NUM_DIGITS-1:0]         digit_en,
  input  logic                          lz_suppress,
  input  logic [BRIGHT_W-1:0]           brightness,
  output logic [NUM_DIGITS-1:0]         anode,
  output logic [7:0]                    cathode,
  output logic [(NUM_DIGITS > 1 ? $clog2(NUM_DIGITS) : 1)-1:0] digit_idx,
  output logic                          frame_tick
);

  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam longint SLOT_L = 64'd1_000_000_000 /
      (longint'(CLK_PER) * longint'(REFR_RATE) * longint'(NUM_DIGITS));
  localparam int SLOT = int'(SLOT_L);
  localparam int SW   = (SLOT > 1) ? $clog2(SLOT) : 1;
  localparam logic [SW-1:0] SLOT_LAST = SW'(SLOT - 1);
  localparam logic [SW-1:0] BLANK_V   = SW'(BLANK_CYC);
  localparam logic [IW-1:0] IDX_LAST  = IW'(NUM_DIGITS - 1);

  if (SLOT <= BLANK_CYC || NUM_DIGITS < 1 || NUM_DIGITS > 16) begin : g_param_err
    $error("seg_display_scanner: slot too short for blanking or NUM_DIGITS out of 1..16");
  end

  logic [SW-1:0]           slot_cnt_q, slot_cnt_d;
  logic [IW-1:0]           digit_idx_q, digit_idx_d;
  logic                    wrapped_q, wrapped_d;
  logic [4*NUM_DIGITS-1:0] digits_s_q;
  logic [NUM_DIGITS-1:0]   dp_s_q, en_s_q;
  logic                    lz_s_q;
  logic [BRIGHT_W-1:0]     bright_s_q;
  logic [NUM_DIGITS-1:0]   anode_q, anode_d;
  logic [7:0]              cathode_q, cathode_d;
  logic                    frame_tick_q, frame_tick_d;

  logic                    at_slot_end, at_frame_end, snap_load;
  logic                    active, lit;
  logic [BRIGHT_W-1:0]     pwm_cnt;
  logic [3:0]              nibble;
  logic [6:0]              seg;
  logic [NUM_DIGITS-1:0]   suppress;
  logic [NUM_DIGITS:1]     zero_from;

  assign at_slot_end  = (slot_cnt_q == SLOT_LAST);
  assign at_frame_end = at_slot_end && (digit_idx_q == IDX_LAST);
  // Holding the snapshot open while disabled makes the first enabled frame fresh.
  assign snap_load    = !enable || at_frame_end;

  always_comb begin
    slot_cnt_d  = slot_cnt_q + SW'(1);
    digit_idx_d = digit_idx_q;
    if (!enable) begin
      slot_cnt_d  = '0;
      digit_idx_d = '0;
    end else if (at_slot_end) begin
      slot_cnt_d  = '0;
      digit_idx_d = (digit_idx_q == IDX_LAST) ? '0 : digit_idx_q + IW'(1);
    end
  end

  // zero_from[d]: snapshot nibbles d..NUM_DIGITS-1 are all zero.
  assign zero_from[NUM_DIGITS] = 1'b1;
  assign suppress[0]           = 1'b0;
  for (genvar gi = 1; gi < NUM_DIGITS; gi++) begin : g_lz
    assign zero_from[gi] = zero_from[gi+1] && (digits_s_q[4*gi +: 4] == 4'h0);
    assign suppress[gi]  = lz_s_q && zero_from[gi];
  end

  function automatic logic [6:0] hex_to_seg(input logic [3:0] n);
    logic [6:0] s;
    case (n)
      4'h0: s = 7'h3F;  4'h1: s = 7'h06;  4'h2: s = 7'h5B;  4'h3: s = 7'h4F;
      4'h4: s = 7'h66;  4'h5: s = 7'h6D;  4'h6: s = 7'h7D;  4'h7: s = 7'h07;
      4'h8: s = 7'h7F;  4'h9: s = 7'h6F;  4'hA: s = 7'h77;  4'hB: s = 7'h7C;
      4'hC: s = 7'h39;  4'hD: s = 7'h5E;  4'hE: s = 7'h79;  default: s = 7'h71;
    endcase
    return s;
  endfunction

  assign nibble  = digits_s_q[{digit_idx_q, 2'b00} +: 4];
  assign seg     = hex_to_seg(nibble);
  assign active  = (slot_cnt_q >= BLANK_V);
  assign pwm_cnt = BRIGHT_W'(slot_cnt_q - BLANK_V);
  assign lit     = (pwm_cnt < bright_s_q) || (&bright_s_q);

  always_comb begin
    anode_d      = '1;
    cathode_d    = 8'hFF;
    frame_tick_d = 1'b0;
    wrapped_d    = enable && at_frame_end;
    if (enable) begin
      // Cathode is driven through the blanking window so it settles before the anode opens.
      cathode_d              = ~{dp_s_q[digit_idx_q], suppress[digit_idx_q] ? 7'h00 : seg};
      anode_d[digit_idx_q]   = ~(active && lit && en_s_q[digit_idx_q]);
      frame_tick_d           = wrapped_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_cnt_q   <= '0;
      digit_idx_q  <= '0;
      wrapped_q    <= 1'b0;
      digits_s_q   <= '0;
      dp_s_q       <= '0;
      en_s_q       <= '0;
      lz_s_q       <= 1'b0;
      bright_s_q   <= '0;
      anode_q      <= '1;
      cathode_q    <= 8'hFF;
      frame_tick_q <= 1'b0;
    end else begin
      slot_cnt_q   <= slot_cnt_d;
      digit_idx_q  <= digit_idx_d;
      wrapped_q    <= wrapped_d;
      anode_q      <= anode_d;
      cathode_q    <= cathode_d;
      frame_tick_q <= frame_tick_d;
      if (snap_load) begin
        digits_s_q <= digits;
        dp_s_q     <= dp;
        en_s_q     <= digit_en;
        lz_s_q     <= lz_suppress;
        bright_s_q <= brightness;
      end
    end
  end

  assign anode      = anode_q;
  assign cathode    = cathode_q;
  assign digit_idx  = digit_idx_q;
  assign frame_tick = frame_tick_q;

endmodule

// File: tb/tb_seg_display_scanner.sv
// Self-checking bench for seg_display_scanner: 4 digits, 20-cycle slots, 4 blank cycles.
module tb_seg_display_scanner;

  localparam int SLOTC = 20;
  localparam int FRAME = 80;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        enable = 1'b0;
  logic [15:0] digits = '0;
  logic [3:0]  dp = '0;
  logic [3:0]  digit_en = '0;
  logic        lz_suppress = 1'b0;
  logic [2:0]  brightness = '0;
  logic [3:0]  anode;
  logic [7:0]  cathode;
  logic [1:0]  digit_idx;
  logic        frame_tick;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  seg_display_scanner #(
    .CLK_PER(10), .REFR_RATE(1_250_000), .NUM_DIGITS(4), .BLANK_CYC(4), .BRIGHT_W(3)
  ) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .digits(digits), .dp(dp),
    .digit_en(digit_en), .lz_suppress(lz_suppress), .brightness(brightness),
    .anode(anode), .cathode(cathode), .digit_idx(digit_idx), .frame_tick(frame_tick)
  );

  typedef struct {
    logic [15:0]     digits;
    logic [3:0]      dp;
    logic [3:0]      en;
    logic            lz;
    logic [2:0]      br;
    logic [3:0][7:0] cath;   // expected cathode per digit slot, {d3,d2,d1,d0}
  } vec_t;

  typedef struct packed {
    logic [3:0] anode;
    logic [7:0] cathode;
    logic       tick;
    logic [1:0] idx;
  } samp_t;

  samp_t exp_q[$];
  vec_t  vecs[9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, req);
  endtask

  function automatic samp_t expect_sample(input vec_t v, input int i);
    samp_t e;
    int s = i / SLOTC;
    int j = i % SLOTC;
    e.anode   = 4'hF;
    if (j >= 4 && ((((j - 4) % 8) < int'(v.br)) || v.br == 3'd7) && v.en[s])
      e.anode[s] = 1'b0;
    e.cathode = v.cath[s];
    e.tick    = (i == 0);
    e.idx     = 2'(((i + 1) / SLOTC) % 4);
    return e;
  endfunction

  task automatic drive_vec(input vec_t v);
    digits      = v.digits;
    dp          = v.dp;
    digit_en    = v.en;
    lz_suppress = v.lz;
    brightness  = v.br;
  endtask

  task automatic wait_tick();
    int n = 1;
    @(negedge clk);
    while (frame_tick !== 1'b1 && n < 300) begin
      @(negedge clk);
      n++;
    end
    check("tick_wait", 32'(frame_tick), 32'd1);
  endtask

  // Entered on the negedge that shows frame_tick; checks all 80 samples of the frame.
  task automatic check_frame(input vec_t v, input string tag, input int chg_at,
                             input logic [15:0] chg_digits);
    samp_t act, e;
    for (int i = 0; i < FRAME; i++) exp_q.push_back(expect_sample(v, i));
    for (int i = 0; i < FRAME; i++) begin
      if (i > 0) @(negedge clk);
      act = {anode, cathode, frame_tick, digit_idx};
      e   = exp_q.pop_front();
      check($sformatf("%s s%0d", tag, i), 32'(act), 32'(e));
      if (i == chg_at) digits = chg_digits;
    end
    $display("frame %s digits=%h dp=%h en=%h lz=%0d br=%0d checked", tag, v.digits, v.dp,
             v.en, v.lz, v.br);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t v1234, v5678;
    samp_t act;
    int n;

    vecs[0] = '{16'h1234, 4'h0, 4'hF, 1'b0, 3'd7, {8'hF9, 8'hA4, 8'hB0, 8'h99}};
    vecs[1] = '{16'h0050, 4'h0, 4'hF, 1'b1, 3'd7, {8'hFF, 8'hFF, 8'h92, 8'hC0}};
    vecs[2] = '{16'h0050, 4'h8, 4'hF, 1'b1, 3'd7, {8'h7F, 8'hFF, 8'h92, 8'hC0}};
    vecs[3] = '{16'h0050, 4'h0, 4'hF, 1'b0, 3'd7, {8'hC0, 8'hC0, 8'h92, 8'hC0}};
    vecs[4] = '{16'h0000, 4'h0, 4'hF, 1'b1, 3'd7, {8'hFF, 8'hFF, 8'hFF, 8'hC0}};
    vecs[5] = '{16'hABCD, 4'h5, 4'hF, 1'b0, 3'd3, {8'h88, 8'h03, 8'hC6, 8'h21}};
    vecs[6] = '{16'h89EF, 4'h0, 4'hF, 1'b0, 3'd0, {8'h80, 8'h90, 8'h86, 8'h8E}};
    vecs[7] = '{16'h1234, 4'h0, 4'h5, 1'b0, 3'd5, {8'hF9, 8'hA4, 8'hB0, 8'h99}};
    vecs[8] = '{16'h0100, 4'h0, 4'hF, 1'b1, 3'd7, {8'hFF, 8'hF9, 8'hC0, 8'hC0}};
    v1234   = vecs[0];
    v5678   = '{16'h5678, 4'h0, 4'hF, 1'b0, 3'd7, {8'h92, 8'h82, 8'hF8, 8'h80}};

    // Reset state
    enable = 1'b1;
    repeat (3) @(negedge clk);
    check("rst anode", 32'(anode), 32'hF);
    check("rst cathode", 32'(cathode), 32'hFF);
    check("rst digit_idx", 32'(digit_idx), 32'd0);
    check("rst frame_tick", 32'(frame_tick), 32'd0);
    rst_n = 1'b1;

    // Table-driven frames; the second tick guarantees the new snapshot is in use
    for (int k = 0; k < 9; k++) begin
      drive_vec(vecs[k]);
      wait_tick();
      wait_tick();
      check_frame(vecs[k], $sformatf("vec%0d", k), -1, 16'h0);
    end

    // Mid-frame change during digit 1's slot only shows up in the following frame
    drive_vec(v1234);
    wait_tick();
    wait_tick();
    check_frame(v1234, "mid_old", 25, 16'h5678);
    @(negedge clk);
    check_frame(v5678, "mid_new", -1, 16'h0);

    // Enable low for 5 cycles blanks and parks the scan
    wait_tick();
    repeat (10) @(negedge clk);
    enable = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      act = {anode, cathode, frame_tick, digit_idx};
      check($sformatf("en_low c%0d", i), 32'(act), 32'({4'hF, 8'hFF, 1'b0, 2'd0}));
    end
    enable = 1'b1;
    @(posedge clk);
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (frame_tick !== 1'b1 && n < 200);
    check("en_tick_dist", 32'(n), 32'd80);
    $display("enable drop: first frame_tick %0d cycles after restart", n);

    // Asynchronous reset mid-slot, between clock edges
    repeat (11) @(negedge clk);
    check("pre_rst anode", 32'(anode), 32'hE);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("async anode", 32'(anode), 32'hF);
    check("async cathode", 32'(cathode), 32'hFF);
    check("async digit_idx", 32'(digit_idx), 32'd0);
    check("async frame_tick", 32'(frame_tick), 32'd0);
    $display("async reset: anode=%h cathode=%h", anode, cathode);
    @(negedge clk);
    rst_n = 1'b1;

    drive_vec(vecs[5]);
    wait_tick();
    wait_tick();
    check_frame(vecs[5], "post_rst", -1, 16'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
